fetch_ctrl: RTL

Instruction-fetch sequencer that owns the PC and the instruction register feeding the decoder's imem_rdata input. It issues one outstanding request at a time to instruction memory over a req/ready + rvalid handshake. It holds the fetched word stable until the execute stage accepts it, and supports PC redirect from branch/jump resolution with discard of stale responses.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default widths and the PC increment.
package fetch_ctrl_pkg;

    localparam int MEMORY_ADDR_W = 32;
    localparam int MEMORY_DATA_W = 32;
    localparam int FETCH_PC_INC  = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and the instruction register,
// keeps a single request outstanding to instruction memory, holds the fetched
// word until execute takes it, and handles branch/jump redirects, including
// dropping the one response that belongs to a superseded request.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = MEMORY_ADDR_W,
    parameter int              DATA_W   = MEMORY_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              discard_reg, discard_next;
    logic              imem_req_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic              inst_valid_reg, inst_valid_next;
    logic [DATA_W-1:0] inst_data_reg, inst_data_next;
    logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
    logic [ADDR_W-1:0] target_pc;

    // Redirect targets are word aligned; the low two bits are forced to zero.
    assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Next-state and datapath selection; redirect overrides everything else.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        discard_next    = discard_reg;
        inst_valid_next = inst_valid_reg;
        inst_data_next  = inst_data_reg;
        inst_pc_next    = inst_pc_reg;
        case (state_reg)
            FETCH_IDLE: begin
                state_next = FETCH_REQ;
                if (redirect_valid) begin
                    pc_next = target_pc;
                end
            end
            FETCH_REQ: begin
                if (imem_ready) begin
                    state_next = FETCH_WAIT;
                end
                if (redirect_valid) begin
                    pc_next = target_pc;
                    // An accepted request to the old pc will still answer.
                    if (imem_ready) begin
                        discard_next = 1'b1;
                    end
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        pc_next      = target_pc;
                        discard_next = 1'b0;
                        state_next   = FETCH_REQ;
                    end else if (discard_reg) begin
                        discard_next = 1'b0;
                        state_next   = FETCH_REQ;
                    end else begin
                        inst_data_next  = imem_rdata;
                        inst_pc_next    = pc_reg;
                        pc_next         = pc_reg + ADDR_W'(FETCH_PC_INC);
                        inst_valid_next = 1'b1;
                        state_next      = FETCH_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_next      = target_pc;
                    discard_next = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid) begin
                    inst_valid_next = 1'b0;
                    pc_next         = target_pc;
                    state_next      = FETCH_REQ;
                end else if (inst_ready) begin
                    inst_valid_next = 1'b0;
                    state_next      = FETCH_REQ;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    // FSM state, PC, instruction register and registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH_IDLE;
            pc_reg         <= RESET_PC;
            discard_reg    <= 1'b0;
            imem_req_reg   <= 1'b0;
            imem_addr_reg  <= RESET_PC;
            inst_valid_reg <= 1'b0;
            inst_data_reg  <= '0;
            inst_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            discard_reg    <= discard_next;
            imem_req_reg   <= (state_next == FETCH_REQ);
            imem_addr_reg  <= pc_next;
            inst_valid_reg <= inst_valid_next;
            inst_data_reg  <= inst_data_next;
            inst_pc_reg    <= inst_pc_next;
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = imem_addr_reg;
    assign inst_valid = inst_valid_reg;
    assign inst_data  = inst_data_reg;
    assign inst_pc    = inst_pc_reg;

endmodule
